lsu_data_port: RTL and testbench
================================

Name: lsu_data_port

Overview:
Load/store unit between the RV32 execute stage and the single-port synchronous data SRAM.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the active-low data memory bus, which has no byte enables.
- Handles byte/half/word alignment, sign/zero extension, and read-modify-write for sub-word stores.
- Returns one registered response per request.

Parameters:
DATA_WIDTH, 32, width of data and byte address; fixed at 32 (4 byte lanes).

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  DATA_WIDTH  byte address (rs1+imm, computed upstream)
req_wdata  in  DATA_WIDTH  store data (rs2), value in low bits
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
rsp_err  out  1  misaligned address or illegal funct3
data_address  out  DATA_WIDTH  word-aligned byte address {addr[31:2],2'b00}
r_data  in  DATA_WIDTH  SRAM read data, valid the cycle after a read strobe
w_data  out  DATA_WIDTH  SRAM write data
data_csn  out  1  chip select, active low
data_wen  out  1  write enable, active low (1 = read)

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- All outputs are registered.
- Reset values: data_csn=1, data_wen=1, data_address=0, w_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Byte lane = addr[1:0], little-endian. Half lane = addr[1].
- Legal load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- Legal store funct3: SB=000, SH=001, SW=010.
- Error check at the accept edge:
  - Error cases: illegal funct3, LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0.
  - No bus strobe.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - State stays IDLE.
- States: IDLE, READ, CAPTURE, MERGE, WRITE.
- Transitions are given relative to the accept edge E0 (the edge where req_valid && req_ready).
- Load:
  - IDLE -> READ: cycle 1 has csn=0, wen=1.
  - READ -> CAPTURE: cycle 2, r_data valid.
  - At E2: extract the lane, sign- or zero-extend, go to IDLE.
  - Cycle 3: rsp_valid=1.
- SW:
  - IDLE -> WRITE: cycle 1 has csn=0, wen=0, w_data=req_wdata.
  - At E1 go to IDLE; cycle 2: rsp_valid=1.
- SB/SH:
  - IDLE -> READ: cycle 1 read.
  - MERGE: cycle 2, replace the lane in r_data with the low bits of the latched wdata; register the merged word.
  - WRITE: cycle 3, csn=0, wen=0.
  - Cycle 4: rsp_valid=1.
- Request fields are latched at accept; inputs may change afterwards.
- Outside the strobe cycle, csn=1 and wen=1. w_data and data_address hold their last value.
- rsp_valid lasts exactly one cycle. rsp_rdata and rsp_err hold until the next response.
- A new request may be accepted in the same cycle that rsp_valid=1 (back-to-back allowed).
- No two strobes are ever issued in adjacent cycles except READ/MERGE followed by WRITE.
- rst asserted in any state:
  - Abort next edge; no response, no write.
  - If asserted in MERGE, the pending WRITE never occurs.
- req_valid while not ready is ignored; no queuing.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t.
  - Opcode-class constants shared with core.
- One sub-module, lsu_align (combinational):
  - load extract/extend given r_data, addr[1:0], funct3.
  - store merge given old word, wdata, addr[1:0], funct3.
  - misalign/illegal flag.

Test Plan:
- Preload word 0x10=0x8899AABB; LB @0x11 -> csn low in cycle 1 only; rsp_valid in cycle 3; rsp_rdata=0xFFFFFFAA; rsp_err=0.
- Same word: LBU @0x13 -> 0x00000088; LH @0x12 -> 0xFFFF8899; LHU @0x12 -> 0x00008899; LW @0x10 -> 0x8899AABB.
- SB @0x12, wdata=0x12345677 -> cycle1 read, cycle3 write 0x8877AABB at address 0x10, rsp_valid cycle 4; following LW @0x10 returns 0x8877AABB.
- SW @0x20, 0xDEADBEEF -> single strobe cycle 1 (csn=0, wen=0, address 0x20), rsp_valid cycle 2; immediate back-to-back LW @0x20 accepted in cycle 2 returns 0xDEADBEEF.
- LW @0x22 and load funct3=011 @0x10 -> no csn strobe, rsp_valid+rsp_err=1 in cycle 1, rsp_rdata=0.
- SB @0x10 with rst asserted during MERGE -> no write strobe, no rsp_valid, outputs at reset values, word 0x10 unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_data_port_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding, opcode classes used by the core, and a funct3 legality helper.
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;

    // RV32 load/store funct3 encodings (size in [1:0], unsigned flag in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes of the instruction classes that reach this unit
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        LSU_IDLE    = 3'd0,
        LSU_READ    = 3'd1,
        LSU_CAPTURE = 3'd2,
        LSU_MERGE   = 3'd3,
        LSU_WRITE   = 3'd4
    } lsu_state_t;

    // Stores only exist for B/H/W; loads add the unsigned B/H variants
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// Execute-stage request/response channel plus the active-low data SRAM bus.
// slave is the load/store unit; master is its environment (core + SRAM).
interface lsu_data_port_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] data_address;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  data_csn;
    logic                  data_wen;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, r_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               data_address, w_data, data_csn, data_wen
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, r_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               data_address, w_data, data_csn, data_wen
    );
endinterface

// File: rtl/lsu_data_port_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge into
// the old SRAM word, and the misaligned/illegal-funct3 flag.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data,
    output logic        o_err
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_misalign;
    logic [3:0]  w_byte_hit;
    logic [3:0]  w_half_hit;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Sign- or zero-extend the selected lane into a full word
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            F3_W:    o_load_data = i_rdata;
            default: o_load_data = '0;
        endcase
    end

    // Each byte lane takes new data when the store size/offset covers it
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_byte_hit[gi] = (i_funct3 == F3_B) && (i_addr_lo == 2'(gi));
        assign w_half_hit[gi] = (i_funct3 == F3_H) && (i_addr_lo[1] == 1'(gi / 2));
        assign o_merge_data[gi*8 +: 8] =
            w_byte_hit[gi] ? i_wdata[7:0] :
            w_half_hit[gi] ? i_wdata[(gi % 2)*8 +: 8] :
                             i_rdata[gi*8 +: 8];
    end

    // Halfwords need even addresses, words need 4-byte alignment
    assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    assign o_err = !f3_legal(i_is_store, i_funct3) || w_misalign;

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit between the RV32 execute stage and a single-port
// synchronous data SRAM without byte enables. Sub-word stores are done as
// read-modify-write. One request in flight, one registered response each.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    lsu_data_port_if.slave   bus
);
    localparam logic [2:0] S_IDLE    = LSU_IDLE;
    localparam logic [2:0] S_READ    = LSU_READ;
    localparam logic [2:0] S_CAPTURE = LSU_CAPTURE;
    localparam logic [2:0] S_MERGE   = LSU_MERGE;
    localparam logic [2:0] S_WRITE   = LSU_WRITE;

    logic [2:0]            r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic [15:0]           r_wdata;
    logic                  r_csn;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_sel_we;
    logic [2:0]            w_sel_funct3;
    logic [1:0]            w_sel_addr_lo;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merge_data;
    logic                  w_err;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = bus.req_valid && w_idle;

    // In IDLE the checker looks at the live request; afterwards the
    // latched fields drive extraction and merging.
    assign w_sel_we      = w_idle ? bus.req_we         : r_we;
    assign w_sel_funct3  = w_idle ? bus.req_funct3     : r_funct3;
    assign w_sel_addr_lo = w_idle ? bus.req_addr[1:0]  : r_addr_lo;

    lsu_align u_align (
        .i_rdata      (bus.r_data),
        .i_wdata      (r_wdata),
        .i_addr_lo    (w_sel_addr_lo),
        .i_funct3     (w_sel_funct3),
        .i_is_store   (w_sel_we),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data),
        .o_err        (w_err)
    );

    // Request FSM; bus strobes and the response are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_wdata     <= '0;
            r_csn       <= 1'b1;
            r_wen       <= 1'b1;
            r_address   <= '0;
            r_w_data    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_csn       <= 1'b1;
            r_wen       <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we      <= bus.req_we;
                        r_funct3  <= bus.req_funct3;
                        r_addr_lo <= bus.req_addr[1:0];
                        r_wdata   <= bus.req_wdata[15:0];
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_address <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                            r_csn     <= 1'b0;
                            if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                                // Full-word store goes straight out
                                r_wen    <= 1'b0;
                                r_w_data <= bus.req_wdata;
                                r_state  <= S_WRITE;
                            end else begin
                                // Loads and sub-word stores read first
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    r_state <= r_we ? S_MERGE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load_data;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_MERGE: begin
                    r_w_data <= w_merge_data;
                    r_csn    <= 1'b0;
                    r_wen    <= 1'b0;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_idle;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.data_address = r_address;
    assign bus.w_data       = r_w_data;
    assign bus.data_csn     = r_csn;
    assign bus.data_wen     = r_wen;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: SRAM model on the data bus, response scoreboard
// (value, error flag and arrival cycle) and a log of every bus strobe.
module tb_lsu_data_port;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    lsu_data_port_if #(.DATA_WIDTH(32)) bus ();

    lsu_data_port #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    exp_t        sb_q[$];
    strobe_t     log_q[$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] sram    [0:63];
    logic [31:0] sram_rd;
    logic        sram_load;
    logic        prev_strobe;
    logic        prev_wen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return (32'h01010101 * i) ^ 32'hA5A50000;
    endfunction

    // SRAM: one-cycle registered read, write on strobe with wen low
    always @(posedge clk) begin
        if (sram_load) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
            sram_rd <= '0;
        end else if (!bus.data_csn) begin
            if (!bus.data_wen) sram[bus.data_address[7:2]] <= bus.w_data;
            else               sram_rd <= sram[bus.data_address[7:2]];
        end
    end
    assign bus.r_data = sram_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] t;
        w = ref_mem[a[7:2]];
        t = w >> (a[1:0] * 8);
        case (f3)
            3'd0:    return {{24{t[7]}}, t[7:0]};
            3'd4:    return {24'h0, t[7:0]};
            3'd1:    return {{16{t[15]}}, t[15:0]};
            3'd5:    return {16'h0, t[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        sh   = a[1:0] * 8;
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        mask = mask << sh;
        ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~mask) | ((wd << sh) & mask);
    endtask

    function automatic int ref_lat(input logic we, input logic [2:0] f3, input bit err);
        if (err) return 1;
        if (!we) return 3;
        if (f3 == 3'd2) return 2;
        return 4;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && !bus.data_csn) begin
            check_eq("strobe_spacing",
                     {31'b0, prev_strobe && (!prev_wen || bus.data_wen)}, 32'd0);
            log_q.push_back('{cyc, bus.data_wen, bus.data_address, bus.w_data});
        end
        prev_strobe <= !bus.data_csn;
        prev_wen    <= bus.data_wen;
        if (bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
                check_eq("rsp_err",   {31'b0, bus.rsp_err}, {31'b0, e.err});
                check_eq("rsp_cycle", 32'(cyc), 32'(e.due));
                $display("rsp cycle=%0d rdata=0x%08h err=%0b", cyc, bus.rsp_rdata, bus.rsp_err);
            end
        end
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
            check_eq("rsp_missing", 32'(cyc), 32'(sb_q[0].due));
            void'(sb_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input bit expect_rsp, output int k);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        k = cyc;
        $display("req cycle=%0d we=%0b f3=%0d addr=0x%08h wdata=0x%08h", cyc, we, f3, a, wd);
        if (expect_rsp) begin
            sb_q.push_back('{exp_rd, exp_err, cyc + ref_lat(we, f3, exp_err)});
            if (we && !exp_err) ref_store(f3, a, wd);
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_strobe(input string tag, input int idx, input int exp_cyc,
                                input logic exp_wen, input logic [31:0] exp_addr);
        if (idx >= log_q.size()) begin
            check_eq({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            check_eq({tag, "_cycle"}, 32'(log_q[idx].cyc), 32'(exp_cyc));
            check_eq({tag, "_wen"},   {31'b0, log_q[idx].wen}, {31'b0, exp_wen});
            check_eq({tag, "_addr"},  log_q[idx].addr, exp_addr);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int k2;
        int nw;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rwd;
        bit          rerr;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        prev_strobe = 1'b0;
        prev_wen    = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rst       = 1'b1;
        sram_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_csn",     {31'b0, bus.data_csn},  32'd1);
        check_eq("reset_wen",     {31'b0, bus.data_wen},  32'd1);
        check_eq("reset_address", bus.data_address,       32'd0);
        check_eq("reset_wdata",   bus.w_data,             32'd0);
        check_eq("reset_rsp",     {29'b0, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'd0);
        check_eq("reset_rdata",   bus.rsp_rdata,          32'd0);
        rst       = 1'b0;
        sram_load = 1'b0;
        @(negedge clk);
        check_eq("reset_ready",   {31'b0, bus.req_ready}, 32'd1);

        // Loads from preloaded word 0x10 = 0x8899AABB
        log_q.delete();
        issue(1'b0, F3_B, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b1, k);
        drain();
        check_eq("lb_strobe_count", 32'(log_q.size()), 32'd1);
        check_strobe("lb_read", 0, k + 1, 1'b1, 32'h10);
        issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000088, 1'b0, 1'b1, k);
        issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF8899, 1'b0, 1'b1, k);
        issue(1'b0, F3_HU, 32'h12, 32'h0, 32'h00008899, 1'b0, 1'b1, k);
        issue(1'b0, F3_W,  32'h10, 32'h0, 32'h8899AABB, 1'b0, 1'b1, k);
        drain();

        // Byte store: read, merge, write, then read back
        log_q.delete();
        issue(1'b1, F3_B, 32'h12, 32'h12345677, 32'h0, 1'b0, 1'b1, k);
        drain();
        check_eq("sb_strobe_count", 32'(log_q.size()), 32'd2);
        check_strobe("sb_read",  0, k + 1, 1'b1, 32'h10);
        check_strobe("sb_write", 1, k + 3, 1'b0, 32'h10);
        if (log_q.size() > 1) check_eq("sb_write_data", log_q[1].wdata, 32'h8877AABB);
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'h8877AABB, 1'b0, 1'b1, k);
        drain();

        // Error cases never touch the bus
        log_q.delete();
        issue(1'b0, F3_W,   32'h22, 32'h0, 32'h0, 1'b1, 1'b1, k);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, k);
        drain();
        check_eq("err_no_strobe", 32'(log_q.size()), 32'd0);

        // Word store followed by a back-to-back load
        log_q.delete();
        issue(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, k);
        issue(1'b0, F3_W, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, k2);
        drain();
        check_eq("b2b_accept_cycle", 32'(k2), 32'(k + 2));
        check_eq("sw_b2b_strobes", 32'(log_q.size()), 32'd2);
        check_strobe("sw_write", 0, k + 1, 1'b0, 32'h20);
        if (log_q.size() > 0) check_eq("sw_write_data", log_q[0].wdata, 32'hDEADBEEF);
        check_strobe("b2b_read", 1, k2 + 1, 1'b1, 32'h20);

        // Reset during MERGE aborts the pending write
        log_q.delete();
        issue(1'b1, F3_B, 32'h10, 32'h00000055, 32'h0, 1'b0, 1'b0, k);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_csn",     {31'b0, bus.data_csn},  32'd1);
        check_eq("abort_wen",     {31'b0, bus.data_wen},  32'd1);
        check_eq("abort_address", bus.data_address,       32'd0);
        check_eq("abort_wdata",   bus.w_data,             32'd0);
        check_eq("abort_rdata",   bus.rsp_rdata,          32'd0);
        check_eq("abort_rsp",     {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready",   {31'b0, bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        nw = 0;
        foreach (log_q[i]) if (!log_q[i].wen) nw++;
        check_eq("abort_no_write", 32'(nw), 32'd0);
        check_eq("abort_word_kept", sram[4], ref_mem[4]);
        issue(1'b0, F3_W, 32'h10, 32'h0, ref_mem[4], 1'b0, 1'b1, k);
        drain();

        // Random mix against the reference model, issued back to back
        for (int n = 0; n < 24; n++) begin
            rwe  = 1'($urandom);
            rf3  = 3'($urandom);
            ra   = 32'($urandom_range(0, 63));
            rwd  = $urandom;
            rerr = ref_err(rwe, rf3, ra);
            issue(rwe, rf3, ra, rwd,
                  (rwe || rerr) ? 32'h0 : ref_load(rf3, ra), rerr, 1'b1, k);
        end
        drain();
        check_eq("final_word4", sram[4], ref_mem[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
